// File: rtl/line_xfer_seq_pkg.sv
// Shared encodings and geometry for the cache line-transfer sequencer.
package line_xfer_seq_pkg;

  localparam logic [3:0] ST_IDLE       = 4'h0;
  localparam logic [3:0] ST_EVICT      = 4'h1;
  localparam logic [3:0] ST_FILL_ISSUE = 4'h2;
  localparam logic [3:0] ST_FILL_DRAIN = 4'h3;
  localparam logic [3:0] ST_DONE       = 4'h4;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned TAG_W          = 5;
  localparam int unsigned IDX_W          = 8;
  localparam int unsigned OFF_W          = 3;
  localparam int unsigned WORD_W         = $clog2(WORDS_PER_LINE);

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] word;
  } ret_entry_t;

  // Byte offset of a 16-bit word within the line.
  function automatic logic [OFF_W-1:0] word_off(input logic [WORD_W-1:0] w);
    return {w, 1'b0};
  endfunction

endpackage

// File: rtl/line_xfer_seq_ret_pipe.sv
// Memory read-return tracker: MEM_LAT-deep shift register of {valid,word}.
module line_ret_pipe
  import line_xfer_seq_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_word_i,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_word_o,
  output logic              empty_o
);

  localparam int unsigned EW = $bits(ret_entry_t);
  localparam int unsigned PW = EW * MEM_LAT;

  logic [PW-1:0] pipe_q;
  logic [PW-1:0] pipe_d;
  ret_entry_t    in_ent;
  ret_entry_t    head;

  always_comb begin
    in_ent.valid = push_i;
    in_ent.word  = push_word_i;
    // New entry enters at the bottom; the oldest falls off the top after presenting.
    pipe_d = PW'({pipe_q, in_ent});
    head   = ret_entry_t'(pipe_q[PW-1 -: EW]);
    // empty_o: nothing left behind the head, so the pipe is drained once it retires.
    empty_o = 1'b1;
    for (int unsigned i = 0; i + 1 < MEM_LAT; i++) begin
      if (pipe_q[EW*i + EW - 1]) empty_o = 1'b0;
    end
  end

  assign out_valid_o = head.valid;
  assign out_word_o  = head.word;

  always_ff @(posedge clk_i) begin
    if (clear_i) pipe_q <= '0;
    else         pipe_q <= pipe_d;
  end

endmodule

// File: rtl/line_xfer_seq.sv
// Line-transfer sequencer: moves a 4-word line cache<->memory for evict and fill.
// Build option CRITICAL_WORD_FIRST_EN: fills start at crit_off and wrap modulo 4.
module line_xfer_seq
  import line_xfer_seq_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned WORDS   = WORDS_PER_LINE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_fill,
  input  logic                   req_evict,
  input  logic [TAG_W+IDX_W-1:0] line_addr,
  input  logic [TAG_W-1:0]       victim_tag,
  input  logic [1:0]             crit_off,
  input  logic [15:0]            cache_data_in,
  input  logic [15:0]            mem_data_in,
  input  logic                   mem_stall,
  output logic                   xfer_busy,
  output logic                   done,
  output logic [OFF_W-1:0]       cache_offset,
  output logic                   cache_wr,
  output logic [15:0]            cache_data_out,
  output logic [15:0]            mem_addr,
  output logic [15:0]            mem_data_out,
  output logic                   mem_rd,
  output logic                   mem_wr
);

  localparam int unsigned WW = $clog2(WORDS);

  logic [3:0]             state_q, state_d;
  logic [WW-1:0]          w_q, w_d;
  logic [WW-1:0]          start_q, start_d;
  logic [TAG_W+IDX_W-1:0] line_q, line_d;
  logic [TAG_W-1:0]       vtag_q, vtag_d;
  logic                   pend_q, pend_d;
  logic                   last_w;
  logic                   push;
  logic                   ret_valid;
  logic [WW-1:0]          ret_word;
  logic                   pipe_empty;
  logic [WW-1:0]          fill_start_now;
  logic [WW-1:0]          fill_start_lat;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [WW-1:0] crit_q;
  always_ff @(posedge clk) begin
    if (rst)                    crit_q <= '0;
    else if (state_q == ST_IDLE) crit_q <= crit_off;
  end
  assign fill_start_now = crit_off;
  assign fill_start_lat = crit_q;
`else
  logic unused_crit;
  assign unused_crit    = ^crit_off;
  assign fill_start_now = '0;
  assign fill_start_lat = '0;
`endif

  line_ret_pipe #(.MEM_LAT(MEM_LAT)) u_ret_pipe (
    .clk_i       (clk),
    .clear_i     (rst),
    .push_i      (push),
    .push_word_i (w_q),
    .out_valid_o (ret_valid),
    .out_word_o  (ret_word),
    .empty_o     (pipe_empty)
  );

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    start_d      = start_q;
    line_d       = line_q;
    vtag_d       = vtag_q;
    pend_d       = pend_q;
    push         = 1'b0;
    done         = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    xfer_busy    = (state_q != ST_IDLE);
    // A burst ends on the word just before its start word, which covers wrapped fills.
    last_w       = ((w_q + WW'(1)) == start_q);

    case (state_q)
      ST_IDLE: begin
        if (req_evict || req_fill) begin
          line_d = line_addr;
          vtag_d = victim_tag;
          pend_d = req_evict & req_fill;
          if (req_evict) begin
            state_d = ST_EVICT;
            w_d     = '0;
            start_d = '0;
          end else begin
            state_d = ST_FILL_ISSUE;
            w_d     = fill_start_now;
            start_d = fill_start_now;
          end
        end
      end
      ST_EVICT: begin
        mem_wr       = 1'b1;
        mem_addr     = {vtag_q, line_q[IDX_W-1:0], w_q, 1'b0};
        mem_data_out = cache_data_in;
        if (!mem_stall) begin
          w_d = w_q + WW'(1);
          if (last_w) begin
            if (pend_q) begin
              state_d = ST_FILL_ISSUE;
              w_d     = fill_start_lat;
              start_d = fill_start_lat;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_FILL_ISSUE: begin
        mem_rd   = 1'b1;
        mem_addr = {line_q, w_q, 1'b0};
        if (!mem_stall) begin
          push = 1'b1;
          w_d  = w_q + WW'(1);
          if (last_w) state_d = ST_FILL_DRAIN;
        end
      end
      ST_FILL_DRAIN: begin
        if (pipe_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cache_wr       = ret_valid;
    cache_data_out = ret_valid ? mem_data_in : '0;
    if (ret_valid)               cache_offset = word_off(ret_word);
    else if (state_q == ST_EVICT) cache_offset = word_off(w_q);
    else                          cache_offset = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      start_q <= '0;
      line_q  <= '0;
      vtag_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      start_q <= start_d;
      line_q  <= line_d;
      vtag_q  <= vtag_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_line_xfer_seq.sv
// Scoreboard bench for line_xfer_seq: expected transfers queued at issue, checked by a monitor.
module tb_line_xfer_seq;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_fill = 1'b0;
  logic        req_evict = 1'b0;
  logic [12:0] line_addr = '0;
  logic [4:0]  victim_tag = '0;
  logic [1:0]  crit_off = '0;
  logic [15:0] cache_data_in;
  logic [15:0] mem_data_in;
  logic        mem_stall = 1'b0;
  logic        xfer_busy, done, cache_wr, mem_rd, mem_wr;
  logic [2:0]  cache_offset;
  logic [15:0] cache_data_out, mem_addr, mem_data_out;

  line_xfer_seq #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_fill(req_fill), .req_evict(req_evict),
    .line_addr(line_addr), .victim_tag(victim_tag), .crit_off(crit_off),
    .cache_data_in(cache_data_in), .mem_data_in(mem_data_in), .mem_stall(mem_stall),
    .xfer_busy(xfer_busy), .done(done), .cache_offset(cache_offset), .cache_wr(cache_wr),
    .cache_data_out(cache_data_out), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_rd(mem_rd), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic [15:0] d; } xact_t;
  typedef struct { int unsigned due; logic [15:0] a; } ret_t;

  xact_t       exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  xact_t       exp_cw_q[$];
  int unsigned exp_done_q[$];
  ret_t        ret_q[$];

  logic [15:0] cline [4];
  int unsigned ksched [8];
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        exp_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb cache_data_in = cline[cache_offset[2:1]];

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ (a * 16'd7) ^ 16'h3C96;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: data for an accepted read appears LAT cycles later, junk otherwise.
  initial begin
    ret_t r;
    mem_data_in = '0;
    forever begin
      @(posedge clk);
      #1;
      while (ret_q.size() != 0 && ret_q[0].due < cyc) void'(ret_q.pop_front());
      if (ret_q.size() != 0 && ret_q[0].due == cyc) begin
        r = ret_q.pop_front();
        mem_data_in = mdata(r.a);
      end else begin
        mem_data_in = 16'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    cmp("xfer_busy", 32'(xfer_busy), 32'(exp_busy));
    cmp("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
    if (mem_wr) begin
      if (exp_wr_q.size() == 0) cmp("unexpected_mem_wr", 32'(mem_wr), 32'd0);
      else begin
        cmp("wr_addr", 32'(mem_addr), 32'(exp_wr_q[0].a));
        cmp("wr_data", 32'(mem_data_out), 32'(exp_wr_q[0].d));
        if (!mem_stall) void'(exp_wr_q.pop_front());
      end
    end
    if (mem_rd) begin
      if (exp_rd_q.size() == 0) cmp("unexpected_mem_rd", 32'(mem_rd), 32'd0);
      else begin
        cmp("rd_addr", 32'(mem_addr), 32'(exp_rd_q[0]));
        if (!mem_stall) begin
          void'(exp_rd_q.pop_front());
          ret_q.push_back('{due: cyc + LAT, a: mem_addr});
        end
      end
    end
    if (cache_wr) begin
      if (exp_cw_q.size() == 0) cmp("unexpected_cache_wr", 32'(cache_wr), 32'd0);
      else begin
        cmp("cache_wr_offset", 32'(cache_offset), 32'(exp_cw_q[0].a));
        cmp("cache_wr_data", 32'(cache_data_out), 32'(exp_cw_q[0].d));
        void'(exp_cw_q.pop_front());
      end
    end
    if (done) begin
      if (exp_done_q.size() == 0) cmp("unexpected_done", 32'(done), 32'd0);
      else cmp("done_cycle", cyc, exp_done_q.pop_front());
    end
  end

  task automatic check_drained();
    cmp("pending_mem_wr", exp_wr_q.size(), 32'd0);
    cmp("pending_mem_rd", exp_rd_q.size(), 32'd0);
    cmp("pending_cache_wr", exp_cw_q.size(), 32'd0);
    cmp("pending_done", exp_done_q.size(), 32'd0);
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_cw_q.delete();
    exp_done_q.delete();
  endtask

  task automatic clear_sched();
    for (int unsigned i = 0; i < 8; i++) ksched[i] = 0;
  endtask

  task automatic rand_sched();
    for (int unsigned i = 0; i < 8; i++)
      ksched[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the IDLE cycle after done.
  task automatic run_xfer(input bit ev, input bit fl, input logic [12:0] la,
                          input logic [4:0] vt, input logic [1:0] co, input bit noise);
    int unsigned n, s, d, t_req;
    bit          st_q[$];
    logic [1:0]  w, start;
    logic [15:0] ad;
    n = (ev ? 4 : 0) + (fl ? 4 : 0);
    s = 0;
    for (int unsigned i = 0; i < n; i++) begin
      s += ksched[i];
      repeat (ksched[i]) st_q.push_back(1'b1);
      st_q.push_back(1'b0);
    end
    d = n + s + (fl ? LAT : 0) + 1;
    for (int unsigned i = 0; i < 4; i++) cline[i] = 16'($urandom);
`ifdef CRITICAL_WORD_FIRST_EN
    start = co;
`else
    start = 2'd0;
`endif
    t_req = cyc;
    if (ev) for (int unsigned i = 0; i < 4; i++) begin
      w = 2'(i);
      exp_wr_q.push_back('{a: {vt, la[7:0], w, 1'b0}, d: cline[i]});
    end
    if (fl) for (int unsigned i = 0; i < 4; i++) begin
      w  = start + 2'(i);
      ad = {la, w, 1'b0};
      exp_rd_q.push_back(ad);
      exp_cw_q.push_back('{a: {13'd0, w, 1'b0}, d: mdata(ad)});
    end
    exp_done_q.push_back(t_req + d);
    req_evict = ev; req_fill = fl; line_addr = la; victim_tag = vt; crit_off = co;
    mem_stall = 1'b0;
    for (int unsigned k = 1; k <= d; k++) begin
      step();
      exp_busy   = 1'b1;
      mem_stall  = (k <= st_q.size()) ? st_q[k-1] : 1'($urandom);
      line_addr  = 13'($urandom);
      victim_tag = 5'($urandom);
      crit_off   = 2'($urandom);
      if (noise) begin
        req_evict = (k == d) ? 1'b1 : 1'($urandom);
        req_fill  = (k == d) ? 1'b1 : 1'($urandom);
      end else begin
        req_evict = 1'b0;
        req_fill  = 1'b0;
      end
    end
    step();
    exp_busy = 1'b0; req_evict = 1'b0; req_fill = 1'b0; mem_stall = 1'b0;
    check_drained();
  endtask

  // Fill aborted by reset in the cycle after its second read is issued.
  task automatic run_reset_mid(input logic [12:0] la);
    logic [15:0] ad;
    for (int unsigned i = 0; i < 4; i++) cline[i] = 16'($urandom);
    for (int unsigned i = 0; i < 3; i++) begin
      ad = {la, 2'(i), 1'b0};
      exp_rd_q.push_back(ad);
      if (i + 1 + LAT <= 3) exp_cw_q.push_back('{a: {13'd0, 2'(i), 1'b0}, d: mdata(ad)});
    end
    req_fill = 1'b1; line_addr = la; crit_off = 2'd0; mem_stall = 1'b0;
    step(); exp_busy = 1'b1; req_fill = 1'b0;
    step();
    step(); rst = 1'b1;
    step(); rst = 1'b0; exp_busy = 1'b0;
    repeat (10) step();
    check_drained();
  endtask

  initial begin
    bit [1:0] sel;
    for (int unsigned i = 0; i < 4; i++) cline[i] = '0;
    clear_sched();
    repeat (3) step();
    cmp("rst_xfer_busy", 32'(xfer_busy), 32'd0);
    cmp("rst_done", 32'(done), 32'd0);
    cmp("rst_cache_wr", 32'(cache_wr), 32'd0);
    cmp("rst_mem_rd", 32'(mem_rd), 32'd0);
    cmp("rst_mem_wr", 32'(mem_wr), 32'd0);
    cmp("rst_cache_offset", 32'(cache_offset), 32'd0);
    cmp("rst_cache_data_out", 32'(cache_data_out), 32'd0);
    cmp("rst_mem_addr", 32'(mem_addr), 32'd0);
    cmp("rst_mem_data_out", 32'(mem_data_out), 32'd0);
    rst = 1'b0;
    step();

    run_xfer(1'b0, 1'b1, 13'h0A5, 5'h00, 2'd2, 1'b0);
    run_xfer(1'b1, 1'b1, {5'h0C, 8'h05}, 5'h1F, 2'd0, 1'b1);
    ksched[1] = 3;
    run_xfer(1'b0, 1'b1, 13'h1234, 5'h00, 2'd0, 1'b0);
    clear_sched();
    run_xfer(1'b1, 1'b0, 13'h0777, 5'h0A, 2'd1, 1'b1);
    run_reset_mid(13'h0BEE);

    for (int unsigned t = 0; t < 40; t++) begin
      sel = 2'($urandom_range(1, 3));
      rand_sched();
      run_xfer(sel[1], sel[0], 13'($urandom), 5'($urandom), 2'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
